// File: rtl/explosao_seq_if.sv
// rtl/explosao_seq_if.sv - control and display bundle between countdown logic, explosao_seq and the board muxes
interface explosao_seq_if #(
   parameter int NUM_HEX  = 8,
   parameter int NUM_LEDR = 18
);
   logic                    TEMPO_ACABOU;
   logic                    TICK;
   logic                    CLR;
   logic [7*NUM_HEX-1:0]    EXPLOSAO_HEX;
   logic [NUM_LEDR-1:0]     EXPLOSAO_LEDR;
   logic                    ATIVO;
   logic [1:0]              ESTADO;

   modport master (
      output TEMPO_ACABOU, TICK, CLR,
      input  EXPLOSAO_HEX, EXPLOSAO_LEDR, ATIVO, ESTADO
   );

   modport slave (
      input  TEMPO_ACABOU, TICK, CLR,
      output EXPLOSAO_HEX, EXPLOSAO_LEDR, ATIVO, ESTADO
   );
endinterface

// File: rtl/explosao_seq.sv
// rtl/explosao_seq.sv - end-of-game flash/blank/"udied" display sequencer; EXPLOSAO_LOOP_EN makes MSG loop back to FLASH
module explosao_seq #(
   parameter int NUM_HEX     = 8,
   parameter int NUM_LEDR    = 18,
   parameter int FLASH_TICKS = 32,
   parameter int BLANK_TICKS = 32,
   parameter int MSG_TICKS   = 64
) (
   input logic          CLOCK,
   input logic          RESET_N,
   explosao_seq_if.slave bus
);
   localparam int MAX_AB = (FLASH_TICKS > BLANK_TICKS) ? FLASH_TICKS : BLANK_TICKS;
   localparam int MAX_T  = (MAX_AB > MSG_TICKS) ? MAX_AB : MSG_TICKS;
   localparam int CW     = $clog2(MAX_T + 1);
   localparam int MSG_DIGITS = (NUM_HEX < 5) ? NUM_HEX : 5;

   localparam logic [CW-1:0] FLASH_LAST = CW'(FLASH_TICKS - 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
`ifdef EXPLOSAO_LOOP_EN
   localparam logic [CW-1:0] MSG_LAST   = CW'(MSG_TICKS - 1);
`endif

   // "udied" with HEX0 in the low bits: d, e, i, d, u
   localparam logic [34:0] MSG_WORD = {7'b1000001, 7'b0100001, 7'b1111001,
                                       7'b0000110, 7'b0100001};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FLASH = 2'd1,
      BLANK = 2'd2,
      MSG   = 2'd3
   } state_t;

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [1:0]           phase;
   logic [6:0]           flash_pat;
   logic [7*NUM_HEX-1:0] hex;
   logic [NUM_LEDR-1:0]  ledr;

   // A 1-bit counter still yields a valid animation phase
   if (CW >= 2) begin : g_phase_wide
      assign phase = cnt[1:0];
   end else begin : g_phase_narrow
      assign phase = {1'b0, cnt};
   end

   // State and tick counter; CLR outranks everything, counter clears on every transition
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (bus.CLR) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.TEMPO_ACABOU) begin
                  state <= FLASH;
                  cnt   <= '0;
               end
            end
            FLASH: begin
               if (bus.TICK) begin
                  if (cnt == FLASH_LAST) begin
                     state <= BLANK;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            BLANK: begin
               if (bus.TICK) begin
                  if (cnt == BLANK_LAST) begin
                     state <= MSG;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            MSG: begin
`ifdef EXPLOSAO_LOOP_EN
               if (bus.TICK) begin
                  if (cnt == MSG_LAST) begin
                     state <= FLASH;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
`endif
            end
            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Rotating segment pattern for the current flash phase
   always_comb begin
      flash_pat = 7'b1111100;
      case (phase)
         2'd0:    flash_pat = 7'b1111100;
         2'd1:    flash_pat = 7'b1110011;
         2'd2:    flash_pat = 7'b1001111;
         default: flash_pat = 7'b0111111;
      endcase
   end

   // Moore decode of digits and LEDs from the registered state and counter
   always_comb begin
      hex  = '1;
      ledr = '0;
      case (state)
         FLASH: begin
            for (int k = 0; k < NUM_HEX; k++) begin
               hex[7*k +: 7] = flash_pat;
            end
            for (int i = 0; i < NUM_LEDR; i++) begin
               ledr[i] = (i[1:0] == phase);
            end
         end
         MSG: begin
            for (int k = 0; k < MSG_DIGITS; k++) begin
               hex[7*k +: 7] = MSG_WORD[7*k +: 7];
            end
         end
         default: begin
            hex  = '1;
            ledr = '0;
         end
      endcase
   end

   assign bus.EXPLOSAO_HEX  = hex;
   assign bus.EXPLOSAO_LEDR = ledr;
   assign bus.ATIVO         = (state != IDLE);
   assign bus.ESTADO        = state;
endmodule
